// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serializer paced by a 16x tick.
// Optional flow control: define UART_TX_CTS_EN to add the cts_n input that gates frame starts.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          oversample_tick,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  input  logic                          parity_en,
  input  logic                          parity_odd,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // state  | meaning
  // IDLE   | line high, waiting for a tick with data queued
  // START  | start bit (low)
  // DATA   | data bits, LSB first, index in bit_q
  // PARITY | parity bit (only when latched parity_en)
  // STOP   | stop bit(s), remaining count in bit_q
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, fifo_empty, cts_ok;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic          tx_d, bit_end, load;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;
  always_ff @(posedge clk) begin
    if (reset) cts_sync <= 2'b11;
    else       cts_sync <= {cts_sync[0], cts_n};
  end
  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign in_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = in_valid && in_ready;
  assign busy       = (state_q != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    pop       = 1'b0;
    load      = 1'b0;
    bit_end   = oversample_tick && (tick_q == '0);

    if (state_q != IDLE && oversample_tick)
      tick_d = (tick_q == '0) ? TW'(OVERSAMPLE - 1) : tick_q - 1'b1;

    case (state_q)
      IDLE:   load = oversample_tick && !fifo_empty && cts_ok;
      START:  if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
              end
      DATA:   if (bit_end) begin
                if (bit_q == 3'd7) begin
                  state_d = par_en_q ? PARITY : STOP;
                  bit_d   = 3'(STOP_BITS - 1);
                end else begin
                  bit_d = bit_q + 1'b1;
                end
              end
      PARITY: if (bit_end) begin
                state_d = STOP;
                bit_d   = 3'(STOP_BITS - 1);
              end
      STOP:   if (bit_end) begin
                if (bit_q != '0) bit_d = bit_q - 1'b1;
                else if (!fifo_empty && cts_ok) load = 1'b1;
                else state_d = IDLE;
              end
      default: state_d = IDLE;
    endcase

    // The closing stop tick doubles as the next start tick, giving gapless frames.
    if (load) begin
      pop       = 1'b1;
      state_d   = START;
      tick_d    = TW'(OVERSAMPLE - 1);
      data_d    = mem[rd_ptr];
      par_en_d  = parity_en;
      par_odd_d = parity_odd;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PARITY:  tx_d = (^data_d) ^ par_odd_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      tx        <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      tx        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single frames, full-FIFO burst, push/pop corners, reset mid-frame.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset, in_valid, parity_en, parity_odd;
  logic [7:0] in_data;
  logic       in_ready, tx, busy;
  logic [4:0] fifo_count;
  logic       tick_en, tick_auto, tick_man, oversample_tick;
  int         div;
  int         compared = 0;
  int         mismatched = 0;

  assign oversample_tick = tick_auto | tick_man;

  uart_tx_fifo #(.FIFO_DEPTH(16), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .oversample_tick(oversample_tick),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks when enabled, updated away from the active edge.
  always @(negedge clk) begin
    if (!tick_en) begin
      tick_auto = 1'b0;
      div = 0;
    end else begin
      div = (div == 3) ? 0 : div + 1;
      tick_auto = (div == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        po;
    int          nbits;
    logic [10:0] frame;   // bit i = i-th bit on the line
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (oversample_tick) k++;
    end
    @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    int guard = 0;
    while (tx !== 1'b0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    if (tx !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: no start bit within 5000 cycles, tx=%b, required 0", name, tx);
    end
  endtask

  // Called right after the start bit begins; returns at mid of the last bit.
  task automatic recv_bits(input int nbits, output logic [10:0] bits);
    bits = '1;
    wait_ticks(8);
    bits[0] = tx;
    for (int i = 1; i < nbits; i++) begin
      wait_ticks(16);
      bits[i] = tx;
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  logic [10:0] bits, mask;
  logic [7:0]  expq[$];
  logic [7:0]  exp_b;
  int          accepted;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; parity_en = 1'b0; parity_odd = 1'b0;
    tick_en = 1'b0; tick_man = 1'b0; tick_auto = 1'b0; div = 0;

    vecs[0] = '{8'h55, 1'b1, 1'b0, 11, 11'b10010101010};
    vecs[1] = '{8'h55, 1'b1, 1'b1, 11, 11'b11010101010};
    vecs[2] = '{8'h80, 1'b0, 1'b0, 10, 11'b01100000000};
    vecs[3] = '{8'hA5, 1'b1, 1'b0, 11, 11'b10101001010};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 11, 11'b11001111000};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 11, 11'b11111111110};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 11, 11'b10000000000};

    @(negedge clk);
    do_reset();
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Single frames; parity inputs are flipped once the frame starts to prove they are latched.
    tick_en = 1'b1;
    for (int v = 0; v < 7; v++) begin
      parity_en  = vecs[v].pe;
      parity_odd = vecs[v].po;
      write_byte(vecs[v].data);
      wait_start($sformatf("vec%0d_start", v));
      parity_en  = ~vecs[v].pe;
      parity_odd = ~vecs[v].po;
      recv_bits(vecs[v].nbits, bits);
      mask = 11'h7FF >> (11 - vecs[v].nbits);
      check($sformatf("vec%0d_frame", v), 32'(bits & mask), 32'(vecs[v].frame & mask));
      check($sformatf("vec%0d_busy_stop", v), 32'(busy), 32'd1);
      wait_ticks(8);
      check($sformatf("vec%0d_busy_end", v), 32'(busy), 32'd0);
    end

    // Full FIFO with the tick held low.
    tick_en = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
    do_reset();
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i * 29 + 3);
      if (in_ready) begin
        accepted++;
        expq.push_back(in_data);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_accepted", 32'(accepted), 32'd16);
    check("full_count", 32'(fifo_count), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_tx_idle", 32'(tx), 32'd1);

    // Push refused while full even though the same cycle pops.
    in_valid = 1'b1; in_data = 8'hEE; tick_man = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; tick_man = 1'b0;
    check("full_pop_count", 32'(fifo_count), 32'd15);
    check("full_pop_in_ready", 32'(in_ready), 32'd1);
    check("full_pop_tx_start", 32'(tx), 32'd0);

    tick_en = 1'b1;
    for (int f = 0; f < 16; f++) begin
      recv_bits(10, bits);
      exp_b = expq.pop_front();
      check($sformatf("burst%0d_frame", f), 32'(bits[9:0]), 32'({1'b1, exp_b, 1'b0}));
      wait_ticks(8);
      if (f < 15) check($sformatf("burst%0d_gapless", f), 32'(tx), 32'd0);
    end
    check("burst_busy_end", 32'(busy), 32'd0);
    check("burst_count_end", 32'(fifo_count), 32'd0);

    // Simultaneous push and pop on a partly filled FIFO.
    tick_en = 1'b0;
    do_reset();
    write_byte(8'h11);
    write_byte(8'h22);
    in_valid = 1'b1; in_data = 8'h33; tick_man = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; tick_man = 1'b0;
    check("pushpop_count", 32'(fifo_count), 32'd2);
    check("pushpop_tx_start", 32'(tx), 32'd0);

    // Reset during data bit 3 aborts the frame and flushes the queue.
    do_reset();
    tick_en = 1'b1;
    write_byte(8'h5A);
    write_byte(8'hC3);
    wait_start("rst_start");
    wait_ticks(8 + 16 * 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    write_byte(8'h96);
    wait_start("postrst_start");
    recv_bits(10, bits);
    check("postrst_frame", 32'(bits[9:0]), 32'({1'b1, 8'h96, 1'b0}));
    wait_ticks(8);
    check("postrst_busy_end", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
